// File: rtl/gates_bist_ctrl.sv
// BIST sequencer: applies the 16 input vectors of a 4-in/10-out gate block and compacts responses into a 16-bit MISR.
// Latency: SETTLE_CYC+1 cycles per vector; done rises 16*(SETTLE_CYC+1) cycles after start is sampled.
// No backpressure: start is only honoured in IDLE/DONE; abort cancels an active run on the next edge.
module gates_bist_ctrl #(
  parameter int unsigned SETTLE_CYC = 1,
  parameter logic [15:0] EXP_SIG    = 16'h0000,
  parameter logic [15:0] SEED       = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  resp,
  output logic [3:0]  vec,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] sig
);

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [3:0]  vec_nxt;
  logic [15:0] sig_nxt;
  logic [15:0] misr;
  logic        pass_nxt;

  // One MISR step: shift with CRC-16-CCITT feedback, fold in the 10 response bits.
  assign misr = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {6'b0, resp};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and datapath next values; abort outranks both capture and the move to DONE.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    sig_nxt   = sig;
    pass_nxt  = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = SETTLE;
          sig_nxt   = SEED;
          idx_nxt   = 4'd0;
          cnt_nxt   = SETTLE_LD;
          pass_nxt  = 1'b0;
        end
      end
      SETTLE: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = 4'd0;
          cnt_nxt   = 4'd0;
          pass_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
          if (cnt == 4'd1) state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort) begin
          state_nxt = IDLE;
          idx_nxt   = 4'd0;
          cnt_nxt   = 4'd0;
          pass_nxt  = 1'b0;
        end else begin
          sig_nxt = misr;
          if (idx == 4'd15) begin
            state_nxt = DONE;
            pass_nxt  = (misr == EXP_SIG);
          end else begin
            state_nxt = SETTLE;
            idx_nxt   = idx + 4'd1;
            cnt_nxt   = SETTLE_LD;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    vec_nxt = (state_nxt == IDLE) ? 4'd0 : idx_nxt;
  end

  // Datapath registers; vec is registered from the next index so it lines up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= 4'd0;
      cnt  <= 4'd0;
      sig  <= 16'h0000;
      pass <= 1'b0;
      vec  <= 4'd0;
    end else begin
      idx  <= idx_nxt;
      cnt  <= cnt_nxt;
      sig  <= sig_nxt;
      pass <= pass_nxt;
      vec  <= vec_nxt;
    end
  end

  assign busy = (state == SETTLE) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_gates_bist_ctrl.sv
// Directed bench for gates_bist_ctrl: two instances (SETTLE_CYC=1 and 3) driven by a behavioral gate model.
// Inputs change 1 time unit after the rising edge and outputs are sampled there too.
// Expected signatures come from a reference MISR fed by the same gate model.
module tb_gates_bist_ctrl;

  // Behavioral gate block: a,b,c,d -> o10..o1.
  function automatic logic [9:0] gate_model(input logic [3:0] v);
    logic a, b, c, d;
    a = v[3]; b = v[2]; c = v[1]; d = v[0];
    return {~(a ^ d), (a & b) | (c & d), b ^ c ^ d, c & d, ~c,
            ~(a | b), ~(a & b), a ^ b, a | b, a & b};
  endfunction

  // Reference signature after the first n captures, optionally with o1 inverted on vector 7.
  function automatic logic [15:0] misr_prefix(input int n, input logic flip);
    logic [15:0] s;
    logic [9:0]  r;
    s = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      if (i < n) begin
        r = gate_model(4'(i));
        if (flip && i == 7) r[0] = ~r[0];
        s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {6'b0, r};
      end
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = misr_prefix(16, 1'b0);

  logic        clk = 1'b0;
  logic        rst0, start0, abort0, flip7;
  logic        rst1, start1, abort1;
  logic [9:0]  resp0, resp1;
  logic [3:0]  vec0, vec1;
  logic        busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] sig0, sig1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign resp0 = gate_model(vec0) ^ {9'b0, (flip7 && vec0 == 4'd7)};
  assign resp1 = gate_model(vec1);

  gates_bist_ctrl #(.SETTLE_CYC(1), .EXP_SIG(GOLD)) u0 (
    .clk(clk), .rst(rst0), .start(start0), .abort(abort0), .resp(resp0),
    .vec(vec0), .busy(busy0), .done(done0), .pass(pass0), .sig(sig0));

  gates_bist_ctrl #(.SETTLE_CYC(3), .EXP_SIG(GOLD)) u1 (
    .clk(clk), .rst(rst1), .start(start1), .abort(abort1), .resp(resp1),
    .vec(vec1), .busy(busy1), .done(done1), .pass(pass1), .sig(sig1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for done on u0 after start was sampled; tallies cycles where vec/busy were off the ramp.
  task automatic wait_done0(output int edges, output int verrs);
    edges = 0; verrs = 0;
    while (!done0 && edges < 200) begin
      if (vec0 !== 4'(edges / 2) || busy0 !== 1'b1) verrs++;
      tick();
      edges++;
    end
  endtask

  task automatic wait_done1(output int edges, output int verrs);
    edges = 0; verrs = 0;
    while (!done1 && edges < 300) begin
      if (vec1 !== 4'(edges / 4) || busy1 !== 1'b1) verrs++;
      tick();
      edges++;
    end
  endtask

  task automatic test_reset();
    rst0 = 1; rst1 = 1; start0 = 1; abort0 = 1; start1 = 0; abort1 = 0; flip7 = 0;
    tick(); tick();
    rst0 = 0; rst1 = 0; start0 = 0; abort0 = 0;
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if ({vec0, busy0, done0, pass0, sig0} !== 23'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got vec=%0d busy=%0b done=%0b pass=%0b sig=%h want all zero",
                 i, vec0, busy0, done0, pass0, sig0);
      end
      tick();
    end
    n_tests++;
    if ({vec1, busy1, done1, pass1, sig1} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_idle_u1 got vec=%0d busy=%0b done=%0b sig=%h want all zero", vec1, busy1, done1, sig1);
    end
  endtask

  task automatic test_run(input logic flip, input logic [15:0] exp_sig, input logic exp_pass);
    int edges, verrs;
    flip7 = flip;
    start0 = 1; tick(); start0 = 0;
    wait_done0(edges, verrs);
    n_tests++;
    if (edges !== 32) begin n_fail++; $display("FAIL run_latency got %0d want 32", edges); end
    n_tests++;
    if (verrs !== 0) begin n_fail++; $display("FAIL run_vec_ramp got %0d bad cycles want 0", verrs); end
    n_tests++;
    if (sig0 !== exp_sig) begin n_fail++; $display("FAIL run_sig got %h want %h", sig0, exp_sig); end
    n_tests++;
    if (pass0 !== exp_pass) begin n_fail++; $display("FAIL run_pass got %0b want %0b", pass0, exp_pass); end
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if ({done0, busy0, vec0, sig0, pass0} !== {1'b1, 1'b0, 4'd15, exp_sig, exp_pass}) begin
      n_fail++;
      $display("FAIL done_hold got done=%0b busy=%0b vec=%0d sig=%h pass=%0b want 1 0 15 %h %0b",
               done0, busy0, vec0, sig0, pass0, exp_sig, exp_pass);
    end
    flip7 = 0;
  endtask

  task automatic test_abort();
    int edges, verrs, k;
    start0 = 1; tick(); start0 = 0;
    k = 0;
    while (vec0 !== 4'd5 && k < 50) begin tick(); k++; end
    abort0 = 1; tick(); abort0 = 0;
    n_tests++;
    if ({busy0, vec0, done0, pass0} !== 7'd0) begin
      n_fail++;
      $display("FAIL abort_idx5 got busy=%0b vec=%0d done=%0b pass=%0b want 0", busy0, vec0, done0, pass0);
    end
    n_tests++;
    if (sig0 !== misr_prefix(5, 1'b0)) begin
      n_fail++; $display("FAIL abort_sig_kept got %h want %h", sig0, misr_prefix(5, 1'b0));
    end
    k = 0;
    for (int i = 0; i < 40; i++) begin if (done0 || busy0) k++; tick(); end
    n_tests++;
    if (k !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d active cycles want 0", k); end
    // Abort on the final capture must suppress both the update and DONE.
    start0 = 1; tick(); start0 = 0;
    for (int i = 0; i < 31; i++) tick();
    abort0 = 1; tick(); abort0 = 0;
    n_tests++;
    if ({done0, busy0, vec0, pass0, sig0} !== {7'd0, misr_prefix(15, 1'b0)}) begin
      n_fail++;
      $display("FAIL abort_last_capture got done=%0b busy=%0b vec=%0d sig=%h want 0 0 0 %h",
               done0, busy0, vec0, sig0, misr_prefix(15, 1'b0));
    end
    start0 = 1; tick(); start0 = 0;
    wait_done0(edges, verrs);
    n_tests++;
    if (edges !== 32 || verrs !== 0 || pass0 !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_rerun got edges=%0d verrs=%0d pass=%0b want 32 0 1", edges, verrs, pass0);
    end
  endtask

  task automatic test_back_to_back();
    int edges, verrs;
    rst0 = 1; tick(); rst0 = 0;
    start0 = 1; tick();
    wait_done0(edges, verrs);
    n_tests++;
    if (edges !== 32 || verrs !== 0) begin
      n_fail++; $display("FAIL held_start_run got edges=%0d verrs=%0d want 32 0", edges, verrs);
    end
    tick();
    n_tests++;
    if ({busy0, done0, vec0, sig0} !== {1'b1, 1'b0, 4'd0, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL held_start_restart got busy=%0b done=%0b vec=%0d sig=%h want 1 0 0 ffff",
               busy0, done0, vec0, sig0);
    end
    wait_done0(edges, verrs);
    start0 = 0;
    n_tests++;
    if (edges !== 32 || verrs !== 0 || sig0 !== GOLD) begin
      n_fail++;
      $display("FAIL held_start_second got edges=%0d verrs=%0d sig=%h want 32 0 %h", edges, verrs, sig0, GOLD);
    end
  endtask

  task automatic test_priority();
    int edges, verrs;
    rst0 = 1; start0 = 1; abort0 = 1; tick();
    rst0 = 0; start0 = 0; abort0 = 0;
    n_tests++;
    if ({busy0, done0, vec0, sig0} !== 22'd0) begin
      n_fail++; $display("FAIL rst_over_start got busy=%0b done=%0b sig=%h want 0", busy0, done0, sig0);
    end
    start0 = 1; abort0 = 1; tick(); start0 = 0; abort0 = 0;
    n_tests++;
    if (busy0 !== 1'b1) begin n_fail++; $display("FAIL start_wins_idle got busy=%0b want 1", busy0); end
    wait_done0(edges, verrs);
    abort0 = 1; tick(); abort0 = 0;
    n_tests++;
    if ({done0, busy0, vec0, sig0, pass0} !== {1'b1, 1'b0, 4'd15, GOLD, 1'b1}) begin
      n_fail++;
      $display("FAIL abort_ignored_done got done=%0b busy=%0b vec=%0d sig=%h pass=%0b want 1 0 15 %h 1",
               done0, busy0, vec0, sig0, pass0, GOLD);
    end
    start0 = 1; abort0 = 1; tick(); start0 = 0; abort0 = 0;
    n_tests++;
    if ({busy0, done0, sig0} !== {1'b1, 1'b0, 16'hFFFF}) begin
      n_fail++; $display("FAIL start_wins_done got busy=%0b done=%0b sig=%h want 1 0 ffff", busy0, done0, sig0);
    end
    rst0 = 1; tick(); rst0 = 0;
  endtask

  task automatic test_settle3();
    int edges, verrs, k;
    start1 = 1; tick(); start1 = 0;
    k = 0;
    while (vec1 !== 4'd10 && k < 100) begin tick(); k++; end
    n_tests++;
    if (k !== 40) begin n_fail++; $display("FAIL s3_reach_idx10 got %0d cycles want 40", k); end
    rst1 = 1; tick(); rst1 = 0;
    n_tests++;
    if ({vec1, busy1, done1, pass1, sig1} !== 23'd0) begin
      n_fail++;
      $display("FAIL s3_midrun_reset got vec=%0d busy=%0b done=%0b pass=%0b sig=%h want 0",
               vec1, busy1, done1, pass1, sig1);
    end
    k = 0;
    for (int i = 0; i < 80; i++) begin if (done1 || busy1) k++; tick(); end
    n_tests++;
    if (k !== 0) begin n_fail++; $display("FAIL s3_no_done_after_reset got %0d want 0", k); end
    start1 = 1; tick(); start1 = 0;
    wait_done1(edges, verrs);
    n_tests++;
    if (edges !== 64 || verrs !== 0) begin
      n_fail++; $display("FAIL s3_latency got edges=%0d verrs=%0d want 64 0", edges, verrs);
    end
    n_tests++;
    if (sig1 !== GOLD || pass1 !== 1'b1) begin
      n_fail++; $display("FAIL s3_sig got sig=%h pass=%0b want %h 1", sig1, pass1, GOLD);
    end
  endtask

  initial begin
    test_reset();
    test_run(1'b0, GOLD, 1'b1);
    test_run(1'b1, misr_prefix(16, 1'b1), 1'b0);
    test_abort();
    test_back_to_back();
    test_priority();
    test_settle3();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/gates_bist_ctrl.md
GATES_BIST_CTRL -- requirements
Module: gates_bist_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1: cycles each vector is held before capture; legal range 1..15.
REQ-002 Parameter EXP_SIG, default 16'h0000: golden 16-bit signature compared at end of run.
REQ-003 Parameter SEED, default 16'hFFFF: MISR initial value loaded on start.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  run request; sampled only in IDLE or DONE.
REQ-007 abort  input  1  cancel an active run.
REQ-008 resp  input  10  gate-block outputs {o10..o1}, o1 in bit 0.
REQ-009 vec  output  4  stimulus {a,b,c,d}, a in bit 3; registered.
REQ-010 busy  output  1  high in SETTLE and CAPTURE.
REQ-011 done  output  1  high while in DONE.
REQ-012 pass  output  1  registered signature-match result; valid only while done=1.
REQ-013 sig  output  16  current MISR contents.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, SETTLE, CAPTURE, DONE.
REQ-015 IDLE: vec=0, busy=0, done=0; start=1 -> load sig<=SEED, idx<=0, cnt<=SETTLE_CYC, go to SETTLE.
REQ-016 vec SHALL equal the 4-bit index idx in every state except IDLE, where it is 0.
REQ-017 SETTLE: cnt decrements each cycle; when cnt==1, go to CAPTURE on the next edge.
REQ-018 SETTLE SHALL therefore last exactly SETTLE_CYC cycles per vector.
REQ-019 CAPTURE (one cycle): sig <= {sig[14:0],1'b0} ^ (sig[15] ? 16'h1021 : 16'h0000) ^ {6'b0,resp}, using resp sampled on that edge.
REQ-020 CAPTURE with idx<15: idx<=idx+1, cnt<=SETTLE_CYC, go to SETTLE.
REQ-021 CAPTURE with idx==15: go to DONE; pass <= (next sig == EXP_SIG).
REQ-022 idx SHALL never wrap: exactly 16 vectors (0..15) are applied and captured per run, in ascending order.
REQ-023 Latency: the first cycle with done=1 SHALL occur 16*(SETTLE_CYC+1) cycles after the edge that samples start (32 cycles at default).
REQ-024 DONE: done=1, busy=0; sig, pass and vec (=15) SHALL hold until leaving DONE.
REQ-025 DONE with start=1 SHALL restart exactly as from IDLE (REQ-015).
REQ-026 start SHALL be ignored while busy=1; the run is not restarted or extended.
REQ-027 abort=1 in SETTLE or CAPTURE -> IDLE on the next edge; done is not asserted, pass<=0, and sig retains its last value.
REQ-028 abort SHALL take priority over the CAPTURE update and over the transition to DONE on the same edge.
REQ-029 abort SHALL be ignored in IDLE and DONE.
REQ-030 start and abort asserted together in IDLE or DONE: start wins.

Reset
REQ-031 rst=1 SHALL force IDLE, vec=0, busy=0, done=0, pass=0, sig=16'h0000, idx=0, cnt=0 on the next edge, in any state.
REQ-032 rst SHALL take priority over start and abort.
REQ-033 rst asserted mid-run SHALL discard the run; no done pulse follows.

Verification
REQ-034 rst held 2 cycles, then released with start=0 -> vec=0, busy=0, done=0, pass=0, sig=0 for 10 cycles.
REQ-035 Default parameters, start pulsed 1 cycle, resp driven by a behavioral model of the gate block -> vec steps 0..15, each held 2 cycles; done=1 exactly 32 cycles after start; sig equals the model-computed MISR value.
REQ-036 EXP_SIG set to that model signature, same run -> pass=1; repeat with resp bit 0 inverted during vector 7 only -> pass=0.
REQ-037 abort pulsed while idx=5 -> busy=0 and vec=0 on the next edge; done stays 0; then start -> full 32-cycle run completes normally.
REQ-038 start held high for the whole run -> exactly one run of 32 cycles; restart occurs on the first DONE cycle.
REQ-039 SETTLE_CYC=3, rst asserted at idx=10 -> IDLE with all outputs at reset values; a new run takes 64 cycles to done.
